// File: rtl/digit_entry_conditioner_pkg.sv
// Shared types for the digit entry front end: FSM state encoding
// and the counter sizing helper.
package EntryPkg;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_PRESS_WAIT   = 3'd1,
      S_FIRE         = 3'd2,
      S_HELD         = 3'd3,
      S_RELEASE_WAIT = 3'd4
   } EntryState;

   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/digit_entry_conditioner_sync.sv
// Two-flop synchronizer for asynchronous board inputs, any width.
// Each bit is synchronized independently; no cross-bit coherence.
module Synchronizer2FF #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] synced
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= '0;
         synced <= '0;
      end else begin
         meta   <= raw;
         synced <= meta;
      end
   end

endmodule

// File: rtl/digit_entry_conditioner.sv
// Debounced digit/enter front end producing a registered digit,
// a one-cycle strobe and a stretched entry clock for the lock core.
module digit_entry_conditioner
   import EntryPkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int PULSE_CYCLES    = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rawEnter,
   input  logic [3:0] rawDigit,
   output logic [3:0] digitOut,
   output logic       entryStrobe,
   output logic       entryClock,
   output logic [1:0] entryIndex,
   output logic       busy
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam int PW = cnt_width(PULSE_CYCLES);

   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_MAX    = '1;
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
   localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

   logic       enS;
   logic [3:0] digS;

   Synchronizer2FF #(.WIDTH(1)) u_sync_enter (
      .clk    (CLK),
      .rst    (RST),
      .raw    (rawEnter),
      .synced (enS)
   );

   Synchronizer2FF #(.WIDTH(4)) u_sync_digit (
      .clk    (CLK),
      .rst    (RST),
      .raw    (rawDigit),
      .synced (digS)
   );

   EntryState state;
   EntryState state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] cnt_inc;
   logic          load_digit;
   logic [PW-1:0] pulse_cnt;

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      load_digit = 1'b0;
      unique case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (enS) begin
               state_nxt = S_PRESS_WAIT;
               cnt_nxt   = CNT_ONE;
            end
         end
         S_PRESS_WAIT: begin
            if (!enS) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (cnt >= DB_LAST) begin
               state_nxt  = S_FIRE;
               load_digit = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_FIRE: begin
            state_nxt = S_HELD;
            cnt_nxt   = '0;
         end
         S_HELD: begin
            if (!enS) begin
               state_nxt = S_RELEASE_WAIT;
               cnt_nxt   = CNT_ONE;
            end
         end
         S_RELEASE_WAIT: begin
            if (enS) begin
               state_nxt = S_HELD;
               cnt_nxt   = '0;
            end else if (cnt >= DB_LAST && !entryClock) begin
               // Hold off re-arming until the lock has seen the whole pulse.
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         entryStrobe <= 1'b0;
         digitOut    <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         busy        <= (state_nxt != S_IDLE);
         entryStrobe <= (state == S_FIRE);
         if (load_digit) begin
            digitOut <= digS;
         end
      end
   end

   // Strobe and clock rise together, one cycle after digitOut loads.
   always_ff @(posedge CLK) begin
      if (RST) begin
         entryClock <= 1'b0;
         pulse_cnt  <= '0;
         entryIndex <= '0;
      end else if (state == S_FIRE) begin
         entryClock <= 1'b1;
         pulse_cnt  <= PULSE_LOAD;
         entryIndex <= entryIndex + 2'd1;
      end else if (entryClock) begin
         pulse_cnt <= pulse_cnt - PULSE_ONE;
         if (pulse_cnt == PULSE_ONE) begin
            entryClock <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_digit_entry_conditioner.sv
// Bench for digit_entry_conditioner: scoreboard of expected entries
// checked at every strobe, plus directed corner-case sequences.
module tb_digit_entry_conditioner;

   localparam int DB  = 4;
   localparam int PC  = 3;
   localparam int LAT = 2 + DB + 1;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       rawEnter = 1'b0;
   logic [3:0] rawDigit = 4'd0;
   logic [3:0] digitOut;
   logic       entryStrobe;
   logic       entryClock;
   logic [1:0] entryIndex;
   logic       busy;

   always #5 CLK = ~CLK;

   digit_entry_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .PULSE_CYCLES    (PC)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .rawEnter    (rawEnter),
      .rawDigit    (rawDigit),
      .digitOut    (digitOut),
      .entryStrobe (entryStrobe),
      .entryClock  (entryClock),
      .entryIndex  (entryIndex),
      .busy        (busy)
   );

   typedef struct {
      logic [3:0] dig;
      logic [1:0] idx;
   } exp_t;

   exp_t sb[$];
   exp_t vec[5];
   logic pat[6];

   int tests = 0;
   int fails = 0;
   int strobes = 0;
   int strobe_run = 0;
   int clk_width = 0;
   int exp_idx = 0;
   int n, lat, s0;
   logic prev_strobe = 1'b0;
   logic prev_clk = 1'b0;
   logic [3:0] prev_dig = 4'd0;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic observe();
      exp_t e;
      if (entryStrobe) begin
         strobes++;
         strobe_run++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: strobe %0d with empty scoreboard", strobes);
         end else begin
            e = sb.pop_front();
            check("strobe_digit", digitOut, e.dig);
            check("strobe_index", entryIndex, e.idx);
         end
      end else if (prev_strobe) begin
         check("strobe_width", strobe_run, 1);
         strobe_run = 0;
      end
      if (entryClock && !prev_clk) begin
         check("clk_with_strobe", entryStrobe, 1);
         check("digit_setup", digitOut, prev_dig);
         clk_width = 1;
      end else if (entryClock) begin
         clk_width++;
      end else if (prev_clk && !RST) begin
         check("clk_width", clk_width, PC);
      end
      prev_strobe = entryStrobe;
      prev_clk    = entryClock;
      prev_dig    = digitOut;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      observe();
   endtask

   task automatic wait_strobe(input string name, input int budget, output int cyc);
      int base;
      base = strobes;
      cyc  = 0;
      while (strobes == base && cyc < budget) begin
         tick();
         cyc++;
      end
      if (strobes == base) begin
         tests++;
         fails++;
         $display("FAIL %s: no strobe within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while (busy && cyc < 60) begin
         tick();
         cyc++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles", cyc);
      end
   endtask

   task automatic expect_entry(input logic [3:0] dig);
      exp_t e;
      exp_idx = (exp_idx + 1) % 4;
      e.dig = dig;
      e.idx = 2'(exp_idx);
      sb.push_back(e);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      exp_idx = 0;
   endtask

   task automatic press(input logic [3:0] dig, input int hold);
      int cyc;
      rawDigit = dig;
      expect_entry(dig);
      rawEnter = 1'b1;
      wait_strobe("press_strobe", 40, cyc);
      check("press_latency", cyc, LAT);
      repeat (hold) tick();
      rawEnter = 1'b0;
      wait_idle();
   endtask

   initial begin
      vec[0] = '{4'd0, 2'd1};
      vec[1] = '{4'd1, 2'd2};
      vec[2] = '{4'd2, 2'd3};
      vec[3] = '{4'd9, 2'd0};
      vec[4] = '{4'd5, 2'd1};
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      // reset values, then button held across reset release
      RST = 1'b1;
      tick();
      tick();
      check("rst_digit", digitOut, 0);
      check("rst_strobe", entryStrobe, 0);
      check("rst_clock", entryClock, 0);
      check("rst_index", entryIndex, 0);
      check("rst_busy", busy, 0);
      rawEnter = 1'b1;
      tick();
      expect_entry(4'd0);
      RST = 1'b0;
      wait_strobe("rst_release_strobe", 40, n);
      check("rst_release_latency", n, LAT);
      repeat (30) tick();
      check("held_one_entry", strobes, 1);
      rawEnter = 1'b0;
      wait_idle();

      // clean press with digit 9
      do_reset();
      rawDigit = 4'd9;
      expect_entry(4'd9);
      s0 = strobes;
      lat = -1;
      rawEnter = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (lat < 0 && strobes != s0) lat = i + 1;
      end
      check("clean_latency", lat, LAT);
      check("clean_strobes", strobes - s0, 1);
      check("clean_index", entryIndex, 1);
      check("clean_digit", digitOut, 9);
      rawEnter = 1'b0;
      wait_idle();

      // bounce rejection
      rawDigit = 4'd5;
      expect_entry(4'd5);
      s0 = strobes;
      for (int i = 0; i < 6; i++) begin
         rawEnter = pat[i];
         tick();
      end
      check("bounce_early", strobes - s0, 0);
      wait_strobe("bounce_strobe", 40, n);
      check("bounce_latency", n + 1, LAT);
      repeat (10) tick();
      rawEnter = 1'b0;
      wait_idle();
      check("bounce_strobes", strobes - s0, 1);

      // digit change while held is ignored
      rawDigit = 4'd2;
      expect_entry(4'd2);
      rawEnter = 1'b1;
      wait_strobe("held_strobe", 40, n);
      repeat (3) tick();
      rawDigit = 4'd7;
      repeat (8) tick();
      check("held_digit", digitOut, 2);
      rawEnter = 1'b0;
      wait_idle();
      check("released_digit", digitOut, 2);
      press(4'd7, 5);
      check("next_digit", digitOut, 7);

      // index wrap over five presses
      do_reset();
      s0 = strobes;
      for (int i = 0; i < 5; i++) begin
         press(vec[i].dig, 4);
         check("wrap_digit", digitOut, vec[i].dig);
         check("wrap_index", entryIndex, vec[i].idx);
      end
      check("wrap_strobes", strobes - s0, 5);

      // reset in the second high cycle of entryClock
      do_reset();
      rawDigit = 4'd3;
      expect_entry(4'd3);
      rawEnter = 1'b1;
      n = 0;
      while (!entryClock && n < 40) begin
         tick();
         n++;
      end
      if (!entryClock) begin
         tests++;
         fails++;
         $display("FAIL midpulse_rise: no entryClock within 40 cycles");
      end
      tick();
      RST = 1'b1;
      tick();
      check("midrst_clock", entryClock, 0);
      check("midrst_busy", busy, 0);
      check("midrst_index", entryIndex, 0);
      exp_idx = 0;
      expect_entry(4'd3);
      s0 = strobes;
      RST = 1'b0;
      wait_strobe("midrst_strobe", 40, n);
      check("midrst_latency", n, LAT);
      repeat (20) tick();
      check("midrst_strobes", strobes - s0, 1);
      rawEnter = 1'b0;
      wait_idle();

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
